// File: rtl/conv_linebuf_ctrl_if.sv
// Pixel handshake and line-buffer FIFO control bundle
// for the conv accelerator line-buffer sequencer.
interface conv_linebuf_ctrl_if #(
  parameter int N = 2
) ();
  logic         pix_valid;
  logic         pix_ready;
  logic [N-1:0] fifo_full;
  logic [N-1:0] fifo_empty;
  logic [N-1:0] fifo_wr_en;
  logic [N-1:0] fifo_rd_en;

  modport master (
    output pix_valid,
    output fifo_full,
    output fifo_empty,
    input  pix_ready,
    input  fifo_wr_en,
    input  fifo_rd_en
  );

  modport slave (
    input  pix_valid,
    input  fifo_full,
    input  fifo_empty,
    output pix_ready,
    output fifo_wr_en,
    output fifo_rd_en
  );
endinterface

// File: rtl/conv_linebuf_ctrl.sv
// Line-buffer sequencer: drives the KSIZE-1 row delay FIFOs,
// tracks frame position, flags full windows, drains at frame end.
module conv_linebuf_ctrl #(
  parameter int IMG_W = 60,
  parameter int IMG_H = 60,
  parameter int KSIZE = 3,
  parameter int COL_W = 6,
  parameter int ROW_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  conv_linebuf_ctrl_if.slave io,
  output logic             win_valid,
  output logic [COL_W-1:0] col_cnt,
  output logic [ROW_W-1:0] row_cnt,
  output logic             busy,
  output logic             done,
  output logic             seq_err
);
  localparam int NF = KSIZE - 1;
  localparam int SK_W = $clog2(KSIZE);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [SK_W-1:0] SK_LAST = SK_W'(KSIZE - 2);

  typedef enum logic [2:0] {
    IDLE, STREAM, SKEW, DRAIN, DONE
  } state_t;

  state_t state, state_nx;

  logic [SK_W-1:0]  skew_cnt;
  logic [COL_W-1:0] cur_col;
  logic [ROW_W-1:0] cur_row;
  logic             accept;
  logic             col_wrap;
  logic             last_px;
  logic [NF-1:0]    acc_q;
  logic [ROW_W-1:0] row_q [NF];
  logic [COL_W-1:0] col_q [NF];
  logic [KSIZE-1:0] acc_d;
  logic [ROW_W-1:0] row_d [KSIZE];
  logic [NF-1:0]    wr_en;
  logic [NF-1:0]    rd_en;
  logic             err_now;

  assign io.pix_ready = (state == STREAM);
  assign accept = io.pix_valid & io.pix_ready;
  assign col_wrap = (cur_col == COL_LAST);
  assign last_px = accept & col_wrap &
                   (cur_row == ROW_LAST);
  assign busy = (state != IDLE);
  assign done = (state == DONE);
  assign acc_d = {acc_q, accept};
  assign io.fifo_wr_en = wr_en;
  assign io.fifo_rd_en = rd_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = STREAM;
      STREAM:  if (last_px) state_nx = SKEW;
      SKEW:    if (skew_cnt == SK_LAST) state_nx = DRAIN;
      DRAIN:   if (&io.fifo_empty) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) skew_cnt <= '0;
    else if (state == SKEW) skew_cnt <= skew_cnt + 1'b1;
    else skew_cnt <= '0;
  end

  // cur_* is the position of the next pixel; *_cnt the last one taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_col <= '0;
      cur_row <= '0;
      col_cnt <= '0;
      row_cnt <= '0;
    end else if (state == IDLE && start) begin
      cur_col <= '0;
      cur_row <= '0;
      col_cnt <= '0;
      row_cnt <= '0;
    end else if (accept) begin
      col_cnt <= cur_col;
      row_cnt <= cur_row;
      cur_col <= col_wrap ? '0 : cur_col + 1'b1;
      if (col_wrap)
        cur_row <= (cur_row == ROW_LAST) ? '0 : cur_row + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      for (int j = 0; j < NF; j++) begin
        row_q[j] <= '0;
        col_q[j] <= '0;
      end
    end else begin
      acc_q[0] <= accept;
      row_q[0] <= cur_row;
      col_q[0] <= cur_col;
      for (int j = 1; j < NF; j++) begin
        acc_q[j] <= acc_q[j-1];
        row_q[j] <= row_q[j-1];
        col_q[j] <= col_q[j-1];
      end
    end
  end

  always_comb begin
    row_d[0] = cur_row;
    for (int k = 1; k < KSIZE; k++) row_d[k] = row_q[k-1];
  end

  // FIFO i lags the input by i cycles, matching the registered
  // read data feeding FIFO i+1
  always_comb begin
    wr_en = '0;
    rd_en = '0;
    win_valid = 1'b0;
    if (state == DRAIN) begin
      rd_en = ~io.fifo_empty;
    end else begin
      for (int i = 0; i < NF; i++) begin
        wr_en[i] = acc_d[i] & (row_d[i] >= ROW_W'(i));
        rd_en[i] = acc_d[i] & (row_d[i] >= ROW_W'(i + 1));
      end
      win_valid = acc_d[NF] &
                  (row_d[NF] >= ROW_W'(NF)) &
                  (col_q[NF-1] >= COL_W'(NF));
    end
  end

  assign err_now = (state != DRAIN) &
                   ((|(wr_en & io.fifo_full)) |
                    (|(rd_en & io.fifo_empty)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       seq_err <= 1'b0;
    else if (err_now) seq_err <= 1'b1;
  end
endmodule

// File: tb/tb_conv_linebuf_ctrl.sv
// Bench for conv_linebuf_ctrl: 4x4 frame, KSIZE=3, FIFO model
// of depth 5, window-timing scoreboard.
module tb_conv_linebuf_ctrl;
  localparam int W = 4;
  localparam int H = 4;
  localparam int K = 3;
  localparam int DEPTH = 5;
  localparam int NF = K - 1;
  localparam int NPIX = W * H;
  localparam int NWIN = (W - K + 1) * (H - K + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic force_full = 1'b0;
  logic win_valid, busy, done, seq_err;
  logic [2:0] col_cnt, row_cnt;

  int occ [NF];
  int max_occ [NF];
  int n_wr [NF];
  int n_rd [NF];
  int n_win, n_done, cyc, win_exp;
  int n_cmp, n_err;
  int pos_col, pos_row;
  int sb [$];

  always #5 clk = ~clk;

  conv_linebuf_ctrl_if #(.N(NF)) io ();

  conv_linebuf_ctrl #(
    .IMG_W(W), .IMG_H(H), .KSIZE(K),
    .COL_W(3), .ROW_W(3)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .io(io),
    .win_valid(win_valid),
    .col_cnt(col_cnt),
    .row_cnt(row_cnt),
    .busy(busy),
    .done(done),
    .seq_err(seq_err)
  );

  // FIFO occupancy model, sharing rst_n with the controller
  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < NF; i++) begin
      if (!rst_n) occ[i] <= 0;
      else occ[i] <= occ[i] + int'(io.fifo_wr_en[i])
                            - int'(io.fifo_rd_en[i]);
    end
  end

  assign io.fifo_empty = {occ[1] == 0, occ[0] == 0};
  assign io.fifo_full = {occ[1] == DEPTH,
                         (occ[0] == DEPTH) || force_full};

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst_n) begin
      pos_col = 0;
      pos_row = 0;
    end else begin
      for (int i = 0; i < NF; i++) begin
        if (io.fifo_wr_en[i]) n_wr[i]++;
        if (io.fifo_rd_en[i]) n_rd[i]++;
        if (occ[i] > max_occ[i]) max_occ[i] = occ[i];
      end
      if (done) n_done++;
      if (start && !busy) begin
        pos_col = 0;
        pos_row = 0;
      end
      if (win_valid) begin
        n_win++;
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL win_extra: win_valid at cycle %0d, none expected",
                   cyc);
        end else begin
          win_exp = sb.pop_front();
          if (cyc !== win_exp) begin
            n_err++;
            $display("FAIL win_time: got cycle %0d want %0d",
                     cyc, win_exp);
          end
        end
      end
      if (io.pix_valid && io.pix_ready) begin
        if (pos_row >= K - 1 && pos_col >= K - 1)
          sb.push_back(cyc + K - 1);
        pos_col++;
        if (pos_col == W) begin
          pos_col = 0;
          pos_row++;
        end
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    io.pix_valid = 1'b0;
    force_full = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    n_cmp++;
    if ({busy, done, win_valid, seq_err, io.pix_ready} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_flags: got %b want 00000",
               {busy, done, win_valid, seq_err, io.pix_ready});
    end
    n_cmp++;
    if ({io.fifo_wr_en, io.fifo_rd_en} !== 4'b0) begin
      n_err++;
      $display("FAIL reset_en: got %b want 0000",
               {io.fifo_wr_en, io.fifo_rd_en});
    end
    n_cmp++;
    if ({row_cnt, col_cnt} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_cnt: got %b want 000000",
               {row_cnt, col_cnt});
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input bit toggle, input bit mid,
                           input bit drain_start, input bit inject,
                           input string tag);
    int acc;
    int guard;
    bit ph;
    bit got;
    for (int i = 0; i < NF; i++) begin
      n_wr[i] = 0;
      n_rd[i] = 0;
      max_occ[i] = 0;
    end
    n_win = 0;
    n_done = 0;
    sb.delete();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    acc = 0;
    guard = 0;
    ph = 1'b0;
    while (acc < NPIX && guard < 200) begin
      io.pix_valid = toggle ? ph : 1'b1;
      ph = ~ph;
      start = mid && (acc == 6);
      force_full = inject && (acc == 3);
      if (io.pix_valid && io.pix_ready) acc++;
      @(posedge clk);
      #1;
      guard++;
    end
    io.pix_valid = 1'b0;
    start = 1'b0;
    force_full = 1'b0;
    n_cmp++;
    if (acc !== NPIX) begin
      n_err++;
      $display("FAIL %s/accepts: got %0d want %0d", tag, acc, NPIX);
    end
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    start = drain_start;
    @(posedge clk);
    #1 start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (got !== 1'b1) begin
      n_err++;
      $display("FAIL %s/done_seen: got %0d want 1", tag, got);
    end
    @(negedge clk);
    n_cmp++;
    if ({done, busy} !== 2'b00 || n_done !== 1) begin
      n_err++;
      $display("FAIL %s/done_pulse: got done=%b busy=%b pulses=%0d want 0 0 1",
               tag, done, busy, n_done);
    end
    n_cmp++;
    if (n_win !== NWIN) begin
      n_err++;
      $display("FAIL %s/win_cnt: got %0d want %0d", tag, n_win, NWIN);
    end
    n_cmp++;
    if (n_wr[0] !== NPIX || n_rd[0] !== NPIX) begin
      n_err++;
      $display("FAIL %s/fifo0: got wr=%0d rd=%0d want %0d %0d",
               tag, n_wr[0], n_rd[0], NPIX, NPIX);
    end
    n_cmp++;
    if (n_wr[1] !== NPIX - W || n_rd[1] !== NPIX - W) begin
      n_err++;
      $display("FAIL %s/fifo1: got wr=%0d rd=%0d want %0d %0d",
               tag, n_wr[1], n_rd[1], NPIX - W, NPIX - W);
    end
    n_cmp++;
    if (max_occ[0] !== W || max_occ[1] !== W) begin
      n_err++;
      $display("FAIL %s/max_occ: got %0d %0d want %0d",
               tag, max_occ[0], max_occ[1], W);
    end
    n_cmp++;
    if (occ[0] !== 0 || occ[1] !== 0) begin
      n_err++;
      $display("FAIL %s/drained: got %0d %0d want 0 0",
               tag, occ[0], occ[1]);
    end
    n_cmp++;
    if (sb.size() !== 0) begin
      n_err++;
      $display("FAIL %s/win_missing: got %0d pending want 0",
               tag, sb.size());
    end
    n_cmp++;
    if (seq_err !== inject) begin
      n_err++;
      $display("FAIL %s/seq_err: got %b want %b", tag, seq_err, inject);
    end
    n_cmp++;
    if (col_cnt !== 3'(W - 1) || row_cnt !== 3'(H - 1)) begin
      n_err++;
      $display("FAIL %s/last_pos: got r%0d c%0d want r%0d c%0d",
               tag, row_cnt, col_cnt, H - 1, W - 1);
    end
  endtask

  task automatic test_stream();
    run_frame(1'b0, 1'b0, 1'b0, 1'b0, "stream");
  endtask

  task automatic test_toggle();
    run_frame(1'b1, 1'b0, 1'b0, 1'b0, "toggle");
  endtask

  task automatic test_start_ignored();
    run_frame(1'b0, 1'b1, 1'b1, 1'b0, "start_ignored");
    repeat (3) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL start_ignored/idle: got busy=%b want 0", busy);
    end
  endtask

  task automatic test_back_to_back();
    run_frame(1'b0, 1'b0, 1'b0, 1'b0, "back_to_back");
  endtask

  task automatic test_reset_midframe();
    int acc;
    int guard;
    sb.delete();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    acc = 0;
    guard = 0;
    io.pix_valid = 1'b1;
    while (acc < 10 && guard < 100) begin
      if (io.pix_ready) acc++;
      @(posedge clk);
      #1;
      guard++;
    end
    #3 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, done, win_valid, seq_err, io.pix_ready} !== 5'b0 ||
        {io.fifo_wr_en, io.fifo_rd_en} !== 4'b0) begin
      n_err++;
      $display("FAIL midreset_out: got %b %b want all zero",
               {busy, done, win_valid, seq_err, io.pix_ready},
               {io.fifo_wr_en, io.fifo_rd_en});
    end
    n_cmp++;
    if ({row_cnt, col_cnt} !== 6'b0) begin
      n_err++;
      $display("FAIL midreset_cnt: got %b want 000000",
               {row_cnt, col_cnt});
    end
    io.pix_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    run_frame(1'b0, 1'b0, 1'b0, 1'b0, "after_reset");
  endtask

  task automatic test_seq_err();
    run_frame(1'b0, 1'b0, 1'b0, 1'b1, "seq_err");
    repeat (4) @(negedge clk);
    n_cmp++;
    if (seq_err !== 1'b1) begin
      n_err++;
      $display("FAIL seq_err_sticky: got %b want 1", seq_err);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (seq_err !== 1'b0) begin
      n_err++;
      $display("FAIL seq_err_clear: got %b want 0", seq_err);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_stream();
    test_toggle();
    test_start_ignored();
    test_back_to_back();
    test_reset_midframe();
    test_seq_err();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared %0d",
             n_cmp);
    $fatal(1);
  end
endmodule

// File: doc/conv_linebuf_ctrl.md
Name: conv_linebuf_ctrl

Overview:
Sequencer for the line-buffer chain of the conv accelerator. It drives wr_en/rd_en of KSIZE-1 cascaded synchronous FIFOs used as row delay lines. It counts frame position and flags when a full KSIZE x KSIZE window is present on the taps. After the frame it drains residual row data so the FIFOs start the next frame empty.

Parameters:
IMG_W, 60, pixels per row; FIFO_DEPTH must be >= IMG_W+1
IMG_H, 60, rows per frame
KSIZE, 3, kernel height/width (>=2); number of FIFOs = KSIZE-1
COL_W, 6, width of col counter (>= clog2(IMG_W))
ROW_W, 6, width of row counter (>= clog2(IMG_H))

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  pulse: begin a frame; honoured only in IDLE
pix_valid  in  1  upstream pixel valid
pix_ready  out  1  controller accepts pixel (high only in STREAM)
fifo_full  in  KSIZE-1  full flags, bit i = FIFO i
fifo_empty  in  KSIZE-1  empty flags, bit i = FIFO i
fifo_wr_en  out  KSIZE-1  write enables, bit i = FIFO i
fifo_rd_en  out  KSIZE-1  read enables, bit i = FIFO i
win_valid  out  1  KSIZE x KSIZE window valid on aligned taps
col_cnt  out  COL_W  column of last accepted pixel
row_cnt  out  ROW_W  row of last accepted pixel
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse at frame completion
seq_err  out  1  sticky protocol error

Behaviour:
- Reset (async, rst_n=0): state=IDLE. All outputs 0, counters 0, skew pipeline cleared, seq_err cleared. FIFOs share rst_n, so a mid-frame reset abandons the frame cleanly.
- accept = pix_valid & pix_ready. Linear position advances only on accept. col wraps at IMG_W-1 to 0 and increments row. No downstream stall; the window consumer is always ready.
- Skew pipeline: acc_d[k], row_d[k], col_d[k] = accept/row/col delayed k cycles, k=0..KSIZE-1 (k=0 is combinational current).
- FIFO i (i=0..KSIZE-2):
  - wr_en_i = acc_d[i] & (row_d[i] >= i)
  - rd_en_i = acc_d[i] & (row_d[i] >= i+1)
  - FIFO 0 is written from the input pixel. FIFO i>0 is written from FIFO i-1 data_out, which is registered (1-cycle read latency), giving 1 cycle of skew per stage.
- Steady state: each FIFO sees simultaneous rd+wr holding IMG_W entries. FIFO_DEPTH >= IMG_W+1 guarantees a write is never dropped on full.
- win_valid = acc_d[KSIZE-1] & (row_d[KSIZE-1] >= KSIZE-1) & (col_d[KSIZE-1] >= KSIZE-1). It is asserted KSIZE-1 cycles after accept of the window's bottom-right pixel. Window count per frame = (IMG_W-KSIZE+1)*(IMG_H-KSIZE+1).
- FSM:
  - IDLE: start -> STREAM; counters zeroed.
  - STREAM: pix_ready=1. Accept of (row IMG_H-1, col IMG_W-1) -> SKEW; pix_ready drops the next cycle.
  - SKEW: wait KSIZE-1 cycles for acc_d to empty (pipeline enables still active) -> DRAIN.
  - DRAIN: rd_en_i = ~fifo_empty_i, wr_en = 0, win_valid = 0. When all fifo_empty = 1 -> DONE.
  - DONE: done=1 for one cycle -> IDLE.
- start outside IDLE is ignored.
- col_cnt/row_cnt hold their last values after the frame until the next start.
- seq_err set (sticky until reset) if wr_en_i & fifo_full_i or rd_en_i & fifo_empty_i in any cycle outside DRAIN.

Test Plan:
- Use IMG_W=4, IMG_H=4, KSIZE=3, FIFO_DEPTH=5. start, then 16 back-to-back pixels -> exactly 4 win_valid pulses; FIFO0 sees 16 wr and 12 rd; FIFO1 sees 12 wr and 8 rd; DRAIN reads 4 from each; done pulse; seq_err=0.
- Same frame with pix_valid toggling 1/0 every cycle -> identical wr/rd/win_valid counts; win_valid always exactly 2 cycles after the causing accept.
- Default params, one full frame -> 58*58=3364 win_valid pulses; max simultaneous FIFO occupancy 60; no seq_err.
- start pulsed during STREAM and DRAIN -> no effect. start in IDLE after done -> second frame gives identical results (FIFOs empty at start).
- rst_n low mid-row 2 -> all outputs 0 immediately (async); after release, a new start runs a clean full frame.
- Force fifo_full[0]=1 during STREAM -> seq_err=1, stays set until rst_n.
